// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types for the sequential magnitude comparator
// FSM state encoding and the one-hot eq/lt/gt result record.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } cmp_state_t;

   typedef struct packed {
      logic eq;
      logic lt;
      logic gt;
   } cmp_result_t;

   localparam cmp_result_t CMP_RESULT_NONE = '0;

endpackage

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational unsigned compare of one W-bit chunk pair
// Exactly one of eq/lt/gt is set in the returned record.
module chunk_cmp
   import cmp_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output cmp_result_t  res_o
);

   always_comb begin
      res_o    = CMP_RESULT_NONE;
      res_o.eq = (a_i == b_i);
      res_o.lt = (a_i <  b_i);
      res_o.gt = (a_i >  b_i);
   end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - multi-cycle MSB-chunk-first magnitude comparator
// CMP_EARLY_EXIT_EN: leave BUSY as soon as the first differing chunk is seen.
module seq_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter int N     = 32,
   parameter int CHUNK = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         signed_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         eq,
   output logic         lt,
   output logic         gt
);

   localparam int NCHUNK = N / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

   cmp_state_t       state_q, state_d;
   logic [N-1:0]     a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             decided_q, decided_d;
   cmp_result_t      res_q, res_d;
   cmp_result_t      chunk_res;
   logic             chunk_diff;
   logic             last_chunk;
   logic             busy_exit;

   chunk_cmp #(.W(CHUNK)) u_chunk_cmp (
      .a_i   (a_q[int'(idx_q) * CHUNK +: CHUNK]),
      .b_i   (b_q[int'(idx_q) * CHUNK +: CHUNK]),
      .res_o (chunk_res)
   );

   assign chunk_diff = !chunk_res.eq;
   assign last_chunk = (idx_q == '0);

`ifdef CMP_EARLY_EXIT_EN
   assign busy_exit = last_chunk || (!decided_q && chunk_diff);
`else
   assign busy_exit = last_chunk;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         idx_q     <= IDX_TOP;
         decided_q <= 1'b0;
         res_q     <= CMP_RESULT_NONE;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         idx_q     <= idx_d;
         decided_q <= decided_d;
         res_q     <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = BUSY;
         BUSY:    if (busy_exit) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      decided_d = decided_q;
      res_d     = res_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Flipping the sign bit maps two's-complement order onto unsigned order.
               a_d        = a;
               b_d        = b;
               a_d[N-1]   = a[N-1] ^ signed_mode;
               b_d[N-1]   = b[N-1] ^ signed_mode;
               idx_d      = IDX_TOP;
               decided_d  = 1'b0;
               res_d      = CMP_RESULT_NONE;
            end
         end
         BUSY: begin
            if (!decided_q && (chunk_diff || last_chunk)) res_d = chunk_res;
            decided_d = decided_q | chunk_diff;
            if (!busy_exit) idx_d = idx_q - 1'b1;
         end
         DONE: begin
            if (out_ready) res_d = CMP_RESULT_NONE;
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      eq        = out_valid & res_q.eq;
      lt        = out_valid & res_q.lt;
      gt        = out_valid & res_q.gt;
   end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - directed self-checking bench for seq_magnitude_comparator
// Latency is counted in cycles, the accept cycle being cycle 0.
module tb_seq_magnitude_comparator;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        signed_mode;
   logic        out_valid;
   logic        out_ready;
   logic        eq;
   logic        lt;
   logic        gt;

   int n_cmp  = 0;
   int n_fail = 0;

`ifdef CMP_EARLY_EXIT_EN
   localparam int LAT_C3 = 2;
   localparam int LAT_C1 = 4;
`else
   localparam int LAT_C3 = 5;
   localparam int LAT_C1 = 5;
`endif

   localparam logic [2:0] R_EQ = 3'b100;
   localparam logic [2:0] R_LT = 3'b010;
   localparam logic [2:0] R_GT = 3'b001;

   always #5 clk = ~clk;

   seq_magnitude_comparator #(.N(32), .CHUNK(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .eq          (eq),
      .lt          (lt),
      .gt          (gt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic accept(input logic [31:0] va, input logic [31:0] vb, input logic sm);
      @(negedge clk);
      a           = va;
      b           = vb;
      signed_mode = sm;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic sm, input logic [2:0] exp_res, input int exp_lat);
      int lat;
      out_ready = 1'b1;
      accept(va, vb, sm);
      wait_valid(lat);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_res"}, {eq, lt, gt}, exp_res);
      check({tag, "_inrdy_done"}, in_ready, 1'b0);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, {in_ready, out_valid, eq, lt, gt}, 5'b10000);
   endtask

   initial begin
      int lat;
      rst         = 1'b1;
      in_valid    = 1'b0;
      a           = '0;
      b           = '0;
      signed_mode = 1'b0;
      out_ready   = 1'b0;
      #12;
      check("reset_outputs", {in_ready, out_valid, eq, lt, gt}, 5'b10000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_release_inrdy", in_ready, 1'b1);

      run_op("equal",       32'h1234_5678, 32'h1234_5678, 1'b0, R_EQ, 5);
      run_op("uns_msb",     32'h8000_0000, 32'h0000_0001, 1'b0, R_GT, LAT_C3);
      run_op("sgn_msb",     32'h8000_0000, 32'h0000_0001, 1'b1, R_LT, LAT_C3);
      run_op("sgn_low",     32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, R_GT, 5);
      run_op("sticky",      32'h0100_0000, 32'h00FF_FFFF, 1'b0, R_GT, LAT_C3);
      run_op("sgn_chunk1",  32'h0000_1000, 32'h0000_2000, 1'b1, R_LT, LAT_C1);
      run_op("uns_low",     32'h0000_0005, 32'h0000_0009, 1'b0, R_LT, 5);

      // Backpressure: result must hold while inputs churn.
      out_ready = 1'b0;
      accept(32'h0000_0003, 32'h0000_0007, 1'b0);
      wait_valid(lat);
      check("bp_lat", lat, 5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a        = $urandom;
         b        = $urandom;
         in_valid = ~in_valid;
         @(posedge clk);
         #1;
         check($sformatf("bp_hold%0d", i), {in_ready, out_valid, eq, lt, gt}, 5'b01010);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", {in_ready, out_valid, eq, lt, gt}, 5'b10000);

      // Reset in the middle of a transaction.
      accept(32'd5, 32'd9, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_outputs", {in_ready, out_valid, eq, lt, gt}, 5'b10000);
      @(negedge clk);
      rst = 1'b0;
      run_op("after_rst", 32'd9, 32'd5, 1'b0, R_GT, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Multi-cycle, parametrised magnitude comparator for the ALU datapath, successor to the single-cycle equality compare.
- Compares two N-bit operands CHUNK bits per cycle, MSB chunk first.
- Reports eq/lt/gt in unsigned or two's-complement signed mode.
- Valid/ready handshakes on input and output, so it can sit between the operand register stage and the flags/branch-resolve stage.

Parameters:
N, 32, operand width in bits; must be an integer multiple of CHUNK.
CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= N.
NCHUNK, N/CHUNK, derived localparam; number of chunks.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair and mode are valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  N  operand A
b  input  N  operand B
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled at accept
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result
eq  output  1  A == B
lt  output  1  A < B in the selected mode
gt  output  1  A > B in the selected mode

Behaviour:
- Reset (async, active-high): state=IDLE, out_valid=0, eq=lt=gt=0, chunk index=NCHUNK-1, decided flag=0.
  - in_ready is decoded from state, so it reads 1 while rst is high and in the cycle after release.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - Latch a and b; in signed mode, invert bit N-1 of both latched copies. This maps signed order to unsigned order.
    - Set idx=NCHUNK-1, clear the decided flag, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle, compare chunk idx of A against chunk idx of B (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK).
  - If the decided flag is 0 and the chunks differ: set lt or gt from the chunk compare, set decided=1.
  - Once set, a decision is sticky; later chunks are ignored.
  - When idx==0 (or on early exit, see Optional Feature): go to DONE. eq=1 if nothing was decided.
  - Otherwise idx decrements by 1.
  - Exactly one of eq/lt/gt is 1 in DONE.
- DONE:
  - out_valid=1; eq/lt/gt are held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE, drop out_valid, clear eq/lt/gt.
  - in_ready=0 throughout DONE; there is no same-cycle accept from DONE.
- Latency, counted from the accept edge to the edge that raises out_valid: (number of chunks examined)+1 cycles.
  - The full scan is NCHUNK+1 cycles.
  - Minimum initiation interval is latency+1, assuming out_ready is held high.
- Operand and mode changes on the inputs while BUSY or DONE have no effect.
- Reset asserted mid-operation: the transaction is aborted and all outputs return to reset values immediately. No partial result is ever presented.
- With N==CHUNK the block degenerates to one compare cycle: latency 2.

Optional Feature:
Macro CMP_EARLY_EXIT_EN.
- Defined: BUSY goes to DONE in the same cycle the first differing chunk is found.
  - Latency is (NCHUNK-idx_of_first_difference)+1.
  - Equal operands still take NCHUNK+1.
- Undefined: BUSY always scans all NCHUNK chunks, giving constant latency NCHUNK+1 for deterministic scheduling. Results are identical in both builds.

Decomposition:
- Package cmp_pkg:
  - State enum typedef cmp_state_t {IDLE, BUSY, DONE}.
  - Packed struct cmp_result_t {eq, lt, gt}.
  - Constant CMP_RESULT_NONE (all zero) for reset/clear.
- Sub-module chunk_cmp, parametrised by W=CHUNK:
  - Purely combinational compare of two W-bit unsigned values.
  - Returns cmp_result_t.
  - Instantiated once and fed by an idx-selected slice.

Test Plan:
(N=32, CHUNK=8, NCHUNK=4)
- Equal: a=b=0x12345678, unsigned, out_ready=1 -> eq=1, lt=gt=0; out_valid exactly 5 cycles after accept in both builds; 1-cycle pulse.
- Unsigned MSB: a=0x80000000, b=0x00000001, signed_mode=0 -> gt=1; out_valid after 2 cycles with CMP_EARLY_EXIT_EN, after 5 without.
- Signed: same operands, signed_mode=1 -> lt=1 (INT_MIN < 1); same latencies as the unsigned MSB case.
- Signed low chunk: a=0xFFFFFFFF, b=0xFFFFFFFE, signed_mode=1 -> gt=1 (-1 > -2); latency 5 in both builds.
- Backpressure: out_ready=0 for 3 cycles after out_valid, toggle a/b/in_valid meanwhile -> result bits stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-op: assert rst 2 cycles after accept of a=5, b=9 -> out_valid/eq/lt/gt=0 immediately; after release, a new accept of a=9, b=5 yields gt=1 with no stale lt.
